// File: rtl/obc_check_pkg.sv
// obc_check_pkg: checker FSM state encoding and Galois LFSR tap masks for widths 4..16.
package obc_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK,
        S_WAIT,
        S_EVAL,
        S_VALID,
        S_SHUTDOWN
    } state_t;

    // Right-shifting Galois taps of maximal-length polynomials.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input int w);
        return (s >> 1) ^ (s[0] ? lfsr_taps(w) : 16'h0000);
    endfunction

endpackage

// File: rtl/obc_challenge_checker_if.sv
// obc_challenge_checker_if: challenge/answer link between the checker (slave) and the OBC side (master).
interface obc_challenge_checker_if #(
    parameter int WIDTH       = 4,
    parameter int NUM_ROUNDS  = 10,
    parameter int MAX_STRIKES = 3
);
    localparam int CW = $clog2(NUM_ROUNDS + 1);
    localparam int SW = $clog2(MAX_STRIKES + 1);

    logic             start;
    logic [WIDTH-1:0] question;
    logic             question_valid;
    logic [WIDTH-1:0] answer_obc;
    logic             answer_valid;
    logic             busy;
    logic             pass;
    logic             override;
    logic             obc_reset;
    logic [CW-1:0]    correct_count;
    logic [SW-1:0]    strike_count;

    modport master (
        output start, answer_obc, answer_valid,
        input  question, question_valid, busy, pass, override, obc_reset, correct_count, strike_count
    );

    modport slave (
        input  start, answer_obc, answer_valid,
        output question, question_valid, busy, pass, override, obc_reset, correct_count, strike_count
    );
endinterface

// File: rtl/challenge_lfsr.sv
// challenge_lfsr: WIDTH-bit maximal-length Galois LFSR, one step per advance, SEED on reset.
module challenge_lfsr
    import obc_check_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SEED  = 'h7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) r_value <= WIDTH'(SEED);
        else if (advance) r_value <= WIDTH'(lfsr_step(16'(r_value), WIDTH));
    end

    assign value = r_value;
endmodule

// File: rtl/obc_challenge_checker.sv
// obc_challenge_checker: challenge/response health check of the primary OBC; after MAX_STRIKES
// consecutive failed campaigns it pulses obc_reset and hands control to the backup.
module obc_challenge_checker
    import obc_check_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int NUM_ROUNDS     = 10,
    parameter int PASS_THRESHOLD = 10,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_STRIKES    = 3,
    parameter int RESET_PULSE    = 8,
    parameter int SEED           = 'h7
) (
    input logic clk,
    input logic reset,
    obc_challenge_checker_if.slave bus
);
    localparam int CW = $clog2(NUM_ROUNDS + 1);
    localparam int SW = $clog2(MAX_STRIKES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(RESET_PULSE + 1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] w_lfsr, w_step, w_exp, r_question;
    logic [CW-1:0]    r_round, r_correct;
    logic [SW-1:0]    r_strike, w_strike_inc;
    logic [TW-1:0]    r_tmo;
    logic [PW-1:0]    r_pulse;
    logic             w_advance, w_timeout, w_done, w_match, w_last, w_fail, w_clear;

    challenge_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk(clk), .reset(reset), .advance(w_advance), .value(w_lfsr)
    );

    // question is loaded with the same next value the LFSR steps to
    assign w_advance    = r_state == S_ASK;
    assign w_step       = WIDTH'(lfsr_step(16'(w_lfsr), WIDTH));
    assign w_exp        = {r_question[WIDTH-1:1] ^ r_question[WIDTH-2:0], ~r_question[0]};
    assign w_timeout    = r_tmo == TW'(TIMEOUT_CYCLES - 1);
    assign w_done       = bus.answer_valid || w_timeout;
    assign w_match      = bus.answer_valid && bus.answer_obc == w_exp;
    assign w_last       = r_round == CW'(NUM_ROUNDS - 1);
    assign w_fail       = r_correct < CW'(PASS_THRESHOLD);
    assign w_strike_inc = r_strike == SW'(MAX_STRIKES) ? r_strike : r_strike + SW'(1);
    assign w_clear      = (r_state == S_IDLE && bus.start) || (r_state == S_EVAL && w_next == S_ASK);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_ASK : S_IDLE;
            S_ASK:   w_next = S_WAIT;
            S_WAIT:  w_next = !w_done ? S_WAIT : (w_last ? S_EVAL : S_ASK);
            S_EVAL:  w_next = !w_fail ? S_VALID : (w_strike_inc == SW'(MAX_STRIKES) ? S_SHUTDOWN : S_ASK);
            S_VALID: w_next = S_IDLE;
            default: w_next = S_SHUTDOWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_question <= '0;
            r_round    <= '0;
            r_correct  <= '0;
            r_strike   <= '0;
            r_tmo      <= '0;
            r_pulse    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ASK) r_question <= w_step;
            r_tmo <= (r_state == S_WAIT && !w_done) ? r_tmo + TW'(1) : '0;
            if (w_clear) begin
                r_round   <= '0;
                r_correct <= '0;
            end else if (r_state == S_WAIT && w_done) begin
                r_round <= r_round == CW'(NUM_ROUNDS) ? r_round : r_round + CW'(1);
                if (w_match && r_correct != CW'(NUM_ROUNDS)) r_correct <= r_correct + CW'(1);
            end
            if (r_state == S_EVAL) r_strike <= w_fail ? w_strike_inc : '0;
            if (r_state == S_SHUTDOWN && r_pulse != PW'(RESET_PULSE)) r_pulse <= r_pulse + PW'(1);
        end
    end

    assign bus.question       = r_question;
    assign bus.question_valid = r_state == S_WAIT;
    assign bus.busy           = r_state == S_ASK || r_state == S_WAIT || r_state == S_EVAL;
    assign bus.pass           = r_state == S_VALID;
    assign bus.override       = r_state == S_SHUTDOWN;
    assign bus.obc_reset      = r_state == S_SHUTDOWN && r_pulse != PW'(RESET_PULSE);
    assign bus.correct_count  = r_correct;
    assign bus.strike_count   = r_strike;
endmodule

// File: tb/tb_obc_challenge_checker.sv
// tb_obc_challenge_checker: directed checks of the default checker plus a PASS_THRESHOLD=7 instance,
// driven from a table of the power-on question sequence and its expected answers.
module tb_obc_challenge_checker;
    typedef struct packed {
        logic [3:0] q;
        logic [3:0] a;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       av = 1'b0;
    logic [3:0] ans = 4'h0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         idx = 0;
    vec_t       tbl [15];

    always #5 clk = ~clk;

    obc_challenge_checker_if bus ();
    obc_challenge_checker_if bus7 ();

    obc_challenge_checker dut (.clk(clk), .reset(reset), .bus(bus));
    obc_challenge_checker #(.PASS_THRESHOLD(7)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

    assign bus.start         = start & ~sel;
    assign bus7.start        = start & sel;
    assign bus.answer_obc    = ans;
    assign bus7.answer_obc   = ans;
    assign bus.answer_valid  = av & ~sel;
    assign bus7.answer_valid = av & sel;

    logic [3:0] m_q, m_cc;
    logic [1:0] m_sc;
    logic       m_qv, m_busy, m_pass, m_ovr, m_orst;
    assign m_q    = sel ? bus7.question       : bus.question;
    assign m_cc   = sel ? bus7.correct_count  : bus.correct_count;
    assign m_sc   = sel ? bus7.strike_count   : bus.strike_count;
    assign m_qv   = sel ? bus7.question_valid : bus.question_valid;
    assign m_busy = sel ? bus7.busy           : bus.busy;
    assign m_pass = sel ? bus7.pass           : bus.pass;
    assign m_ovr  = sel ? bus7.override       : bus.override;
    assign m_orst = sel ? bus7.obc_reset      : bus.obc_reset;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_question", m_q, 0);
        chk("rst_qvalid", m_qv, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_pass", m_pass, 0);
        chk("rst_override", m_ovr, 0);
        chk("rst_obc_reset", m_orst, 0);
        chk("rst_correct", m_cc, 0);
        chk("rst_strike", m_sc, 0);
    endtask

    task automatic wait_qv();
        int k = 0;
        while (!m_qv && k < 64) begin
            tick();
            k++;
        end
        chk("wait_qvalid", m_qv, 1);
    endtask

    // One ten-round campaign; returns at the negedge of the cycle after the last round.
    task automatic run_campaign(input logic [9:0] wrong, input logic [9:0] skip, input int dly);
        int cc = 0;
        int w;
        for (int r = 0; r < 10; r++) begin
            wait_qv();
            chk("question", m_q, tbl[idx].q);
            if (skip[r]) begin
                w = 0;
                while (m_qv && w < 40) begin
                    w++;
                    tick();
                end
                chk("timeout_len", w, 16);
            end else begin
                tick(dly);
                ans = wrong[r] ? ~tbl[idx].a : tbl[idx].a;
                av = 1'b1;
                tick();
                av = 1'b0;
                if (!wrong[r]) cc++;
            end
            chk("correct_count", m_cc, cc);
            idx = (idx + 1) % 15;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl = '{'{4'hF, 4'h0}, '{4'hB, 4'hC}, '{4'h9, 4'hA}, '{4'h8, 4'h9}, '{4'h4, 4'hD},
                '{4'h2, 4'h7}, '{4'h1, 4'h2}, '{4'hC, 4'h5}, '{4'h6, 4'hB}, '{4'h3, 4'h4},
                '{4'hD, 4'h6}, '{4'hA, 4'hF}, '{4'h5, 4'hE}, '{4'hE, 4'h3}, '{4'h7, 4'h8}};
        reset = 1'b1;
        tick(2);
        chk_reset_vals();
        reset = 1'b0;
        ans = 4'h8;
        av = 1'b1;
        tick(2);
        av = 1'b0;
        chk("idle_answer_ignored", m_cc, 0);
        chk("idle_busy", m_busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ask_busy", m_busy, 1);
        chk("ask_qvalid", m_qv, 0);
        run_campaign(10'h000, 10'h000, 2);
        chk("eval_busy", m_busy, 1);
        chk("eval_pass", m_pass, 0);
        tick();
        chk("valid_pass", m_pass, 1);
        chk("valid_busy", m_busy, 0);
        chk("valid_correct", m_cc, 10);
        chk("valid_strike", m_sc, 0);
        tick();
        chk("pass_one_cycle", m_pass, 0);
        chk("idle_keeps_count", m_cc, 10);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            run_campaign(10'h001, 10'h000, 2);
            chk("fail_eval_correct", m_cc, 9);
            tick();
            chk("strike_count", m_sc, c);
            chk("override", m_ovr, int'(c == 3));
            chk("busy_after_eval", m_busy, int'(c < 3));
        end
        n = 0;
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n += int'(m_orst);
            tick();
        end
        start = 1'b0;
        chk("obc_reset_len", n, 8);
        chk("shutdown_override", m_ovr, 1);
        chk("shutdown_ignores_start", m_busy, 0);
        chk("shutdown_strike", m_sc, 3);

        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0;
        idx = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        run_campaign(10'h000, 10'h3FF, 2);
        chk("timeout_eval_correct", m_cc, 0);
        tick();
        chk("timeout_strike", m_sc, 1);
        chk("retry_busy", m_busy, 1);
        wait_qv();
        chk("retry_question", m_q, tbl[idx].q);
        tick(3);
        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0;
        idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_qv();
        chk("restart_question", m_q, tbl[0].q);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        sel = 1'b1;
        idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_campaign(10'h007, 10'h000, 15);
        chk("p7_eval_correct", m_cc, 7);
        tick();
        chk("p7_pass", m_pass, 1);
        chk("p7_strike", m_sc, 0);
        tick();
        chk("p7_idle", m_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
